fir_xifu_offload: RTL and testbench
===================================

FIR_XIFU_OFFLOAD -- requirements
Module: fir_xifu_offload

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4: width of the X-IF instruction ID.
REQ-002 SHALL have parameter NB_OUTSTANDING, default 4, range 1..2^X_ID_WIDTH: maximum results in flight.
REQ-003 SHALL have ports, in this order:
- clk_i  in  1  clock
- rst_ni  in  1  async reset, active-low
- req_valid_i / req_ready_o  in / out  1  core offload request handshake
- req_instr_i, req_rs1_i, req_rs2_i  in  32 each  instruction and operands
- xif_issue_valid_o / xif_issue_ready_i  out / in  1  issue handshake
- xif_issue_instr_o, xif_issue_rs1_o, xif_issue_rs2_o  out  32 each  issued instruction and operands
- xif_issue_id_o  out  X_ID_WIDTH  instruction ID
- xif_issue_accept_i, xif_issue_writeback_i  in  1 each  issue response, valid during the issue handshake
- xif_commit_valid_o  out  1  commit strobe
- xif_commit_id_o  out  X_ID_WIDTH  committed ID
- xif_commit_kill_o  out  1  kill flag
- xif_result_valid_i / xif_result_ready_o  in / out  1  result handshake
- xif_result_id_i  in  X_ID_WIDTH  result ID
- xif_result_data_i  in  32  result data
- xif_result_rd_i  in  5  destination register
- xif_result_we_i  in  1  write enable
- wb_valid_o  out  1  register-file write strobe
- wb_rd_o  out  5  register-file address
- wb_data_o  out  32  register-file data
- illegal_o  out  1  one-cycle pulse: instruction rejected
- err_o  out  1  sticky protocol error
- busy_o  out  1  high when state is not IDLE or outstanding count is nonzero
REQ-004 SHALL use one clock domain (clk_i); reset is asynchronous and active-low (rst_ni).

Function
REQ-005 SHALL implement an FSM with states IDLE, ISSUE and COMMIT.
REQ-006 req_ready_o SHALL be high only when all hold: state is IDLE, outstanding count < NB_OUTSTANDING, and scoreboard[next_id] is clear.
REQ-007 On a req handshake at cycle T, SHALL latch instr/rs1/rs2, enter ISSUE, and drive xif_issue_valid_o=1 from T+1.
REQ-008 In ISSUE, xif_issue_valid_o and all issue payload outputs SHALL hold stable until xif_issue_ready_i=1.
REQ-009 On issue handshake, with accept=1 and writeback=1: SHALL set scoreboard[id] and increment the count.
REQ-010 On issue handshake, with accept=1 and writeback=0: SHALL track nothing.
REQ-011 On issue handshake, with accept=0: SHALL pulse illegal_o for one cycle in the following cycle.
REQ-012 On every issue handshake, SHALL advance next_id modulo 2^X_ID_WIDTH and go to COMMIT.
REQ-013 In COMMIT, SHALL drive xif_commit_valid_o=1 for exactly one cycle, with the just-issued ID and kill = NOT accept, then return to IDLE.
REQ-014 xif_result_ready_o SHALL be constantly 1 outside reset.
REQ-015 On a result handshake with scoreboard[id] set, SHALL clear the bit and decrement the count.
REQ-016 For such a result with we=1 and rd≠0, SHALL drive wb_valid_o/wb_rd_o/wb_data_o one cycle later for one cycle; otherwise no writeback.
REQ-017 A result whose ID is not set in the scoreboard SHALL set err_o and SHALL be dropped, leaving scoreboard and count unchanged.
REQ-018 A simultaneous issue-set and result-clear SHALL update both scoreboard bits and leave the count unchanged.
REQ-019 Minimum throughput SHALL be one offloaded instruction every 3 cycles.

Reset
REQ-020 On rst_ni low, SHALL asynchronously force the following: FSM to IDLE; next_id, count and scoreboard to 0; all valid/strobe outputs, illegal_o and err_o to 0; all payload outputs to 0.
REQ-021 Reset asserted mid-ISSUE or mid-COMMIT SHALL abandon the transaction; no commit is emitted after reset.

Configuration
REQ-022 With FIR_XIFU_OFFLOAD_TIMEOUT_EN defined, SHALL include an 8-bit counter of cycles spent in ISSUE without xif_issue_ready_i.
REQ-023 With FIR_XIFU_OFFLOAD_TIMEOUT_EN defined, when that counter reaches 255, SHALL drop the request, set err_o, keep next_id, and return to IDLE with no commit.
REQ-024 Without FIR_XIFU_OFFLOAD_TIMEOUT_EN, the counter SHALL be absent and ISSUE SHALL wait indefinitely.

Verification
REQ-025 Single instruction: req 0x0000_500B, rs1=3, rs2=5; ready=1, accept=1, writeback=1 -> issue_id=0 at T+1, commit(id 0, kill 0) at T+2; result(id 0, rd 10, data 0x1234, we 1) -> wb_valid, rd 10, data 0x1234 one cycle later.
REQ-026 Back-pressure: issue_ready low 5 cycles -> issue_valid and payload stable for 6 cycles; a second req is stalled meanwhile.
REQ-027 Rejection: accept=0 -> illegal_o one-cycle pulse; commit with kill=1; count stays 0.
REQ-028 Capacity and ID: 4 accepted without results -> req_ready_o=0; one result -> req_ready_o=1 next cycle; after 16 issues the ID wraps 15 -> 0.
REQ-029 Error paths: result with unknown ID 7 -> err_o=1 sticky, no wb_valid; a result in the same cycle as an issue handshake -> count unchanged.
REQ-030 With FIR_XIFU_OFFLOAD_TIMEOUT_EN: issue_ready held low 255 cycles -> err_o=1, FSM returns to IDLE, next_id unchanged.

Source files
------------

// File: rtl/fir_xifu_offload.sv
// fir_xifu_offload
// Offloads one custom instruction at a time from the core to an X-IF
// coprocessor and routes coprocessor results back to the register file.
// A request is latched in IDLE, held on the issue channel in ISSUE until
// the coprocessor takes it, and answered by a single commit strobe in
// COMMIT.
// Results that carry a writeback are tracked by a per-ID scoreboard.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_*                  core offload request (valid/ready, instr, rs1, rs2)
//   xif_issue_*            X-IF issue channel (payload, ID, accept/writeback)
//   xif_commit_*           X-IF commit strobe (ID, kill)
//   xif_result_*           X-IF result channel (always ready outside reset)
//   wb_*                   register-file write port, one cycle after a result
//   illegal_o              one-cycle pulse when the coprocessor rejects
//   err_o                  sticky: unknown result ID or issue timeout
//   busy_o                 FSM not idle or results still outstanding
//
// Optional feature: define FIR_XIFU_OFFLOAD_TIMEOUT_EN to abandon an issue
// that has waited 255 cycles for xif_issue_ready_i (raises err_o).
module fir_xifu_offload #(
  parameter int unsigned X_ID_WIDTH     = 4,
  parameter int unsigned NB_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_instr_i,
  input  logic [31:0]           req_rs1_i,
  input  logic [31:0]           req_rs2_i,
  output logic                  xif_issue_valid_o,
  input  logic                  xif_issue_ready_i,
  output logic [31:0]           xif_issue_instr_o,
  output logic [31:0]           xif_issue_rs1_o,
  output logic [31:0]           xif_issue_rs2_o,
  output logic [X_ID_WIDTH-1:0] xif_issue_id_o,
  input  logic                  xif_issue_accept_i,
  input  logic                  xif_issue_writeback_i,
  output logic                  xif_commit_valid_o,
  output logic [X_ID_WIDTH-1:0] xif_commit_id_o,
  output logic                  xif_commit_kill_o,
  input  logic                  xif_result_valid_i,
  output logic                  xif_result_ready_o,
  input  logic [X_ID_WIDTH-1:0] xif_result_id_i,
  input  logic [31:0]           xif_result_data_i,
  input  logic [4:0]            xif_result_rd_i,
  input  logic                  xif_result_we_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [31:0]           wb_data_o,
  output logic                  illegal_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int unsigned NB_ID = 1 << X_ID_WIDTH;
  localparam int unsigned CW    = X_ID_WIDTH + 1;
  localparam logic [CW-1:0] MAX_OUT = CW'(NB_OUTSTANDING);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, COMMIT = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [31:0]           instr_q, rs1_q, rs2_q;
  logic [X_ID_WIDTH-1:0] nid_q, cid_q;
  logic                  kill_q, illegal_q, err_q;
  logic                  rrdy_q;   // low only in the first cycle out of reset
  logic                  wbv_q;
  logic [4:0]            wbrd_q;
  logic [31:0]           wbdata_q;
  logic [NB_ID-1:0]      sb_q, sb_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic req_hs, iss_hs, res_hs, res_hit, sb_set, timeout;

  assign req_hs  = req_valid_i & req_ready_o;
  assign iss_hs  = xif_issue_valid_o & xif_issue_ready_i;
  assign res_hs  = xif_result_valid_i & rrdy_q;
  assign res_hit = res_hs & sb_q[xif_result_id_i];
  assign sb_set  = iss_hs & xif_issue_accept_i & xif_issue_writeback_i;

`ifdef FIR_XIFU_OFFLOAD_TIMEOUT_EN
  logic [7:0] to_q, to_d;

  // Counts stalled ISSUE cycles; the 255th stalled cycle abandons the issue.
  always_comb begin
    to_d = 8'd0;
    if (state_q == ISSUE && !xif_issue_ready_i) to_d = to_q + 8'd1;
  end

  assign timeout = (state_q == ISSUE) && !xif_issue_ready_i && (to_q == 8'd254);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) to_q <= 8'd0;
    else         to_q <= to_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_hs) state_d = ISSUE;
      ISSUE: begin
        if (iss_hs)       state_d = COMMIT;
        else if (timeout) state_d = IDLE;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready_o        = 1'b0;
    xif_issue_valid_o  = 1'b0;
    xif_commit_valid_o = 1'b0;
    unique case (state_q)
      IDLE:    req_ready_o = rrdy_q && (cnt_q < MAX_OUT) && !sb_q[nid_q];
      ISSUE:   xif_issue_valid_o  = 1'b1;
      COMMIT:  xif_commit_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Scoreboard: set and clear can hit different IDs in the same cycle, in
  // which case the count moves by +1-1 = 0.
  always_comb begin
    sb_d = sb_q;
    if (res_hit) sb_d[xif_result_id_i] = 1'b0;
    if (sb_set)  sb_d[nid_q]           = 1'b1;
    cnt_d = cnt_q;
    unique case ({sb_set, res_hit})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      nid_q     <= '0;
      cid_q     <= '0;
      kill_q    <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
      rrdy_q    <= 1'b0;
      wbv_q     <= 1'b0;
      wbrd_q    <= '0;
      wbdata_q  <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
    end else begin
      rrdy_q <= 1'b1;
      sb_q   <= sb_d;
      cnt_q  <= cnt_d;
      if (req_hs) begin
        instr_q <= req_instr_i;
        rs1_q   <= req_rs1_i;
        rs2_q   <= req_rs2_i;
      end
      if (iss_hs) begin
        cid_q  <= nid_q;
        kill_q <= ~xif_issue_accept_i;
        nid_q  <= nid_q + X_ID_WIDTH'(1);
      end
      illegal_q <= iss_hs & ~xif_issue_accept_i;
      err_q     <= err_q | (res_hs & ~res_hit) | timeout;
      // x0 is hardwired zero, so a write to rd 0 is suppressed
      wbv_q     <= res_hit & xif_result_we_i & (xif_result_rd_i != 5'd0);
      if (res_hit & xif_result_we_i & (xif_result_rd_i != 5'd0)) begin
        wbrd_q   <= xif_result_rd_i;
        wbdata_q <= xif_result_data_i;
      end
    end
  end

  assign xif_issue_instr_o  = instr_q;
  assign xif_issue_rs1_o    = rs1_q;
  assign xif_issue_rs2_o    = rs2_q;
  assign xif_issue_id_o     = nid_q;
  assign xif_commit_id_o    = cid_q;
  assign xif_commit_kill_o  = kill_q;
  assign xif_result_ready_o = rrdy_q;
  assign wb_valid_o         = wbv_q;
  assign wb_rd_o            = wbrd_q;
  assign wb_data_o          = wbdata_q;
  assign illegal_o          = illegal_q;
  assign err_o              = err_q;
  assign busy_o             = (state_q != IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_fir_xifu_offload.sv
// Self-checking bench for fir_xifu_offload: directed scenarios followed by
// random offloads/results, checked against a transaction-level model (list
// of in-flight IDs, next ID, sticky error flag).
module tb_fir_xifu_offload;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_instr, req_rs1, req_rs2;
  logic        iss_valid, iss_ready, iss_accept, iss_wb;
  logic [31:0] iss_instr, iss_rs1, iss_rs2;
  logic [3:0]  iss_id, cmt_id, res_id;
  logic        cmt_valid, cmt_kill;
  logic        res_valid, res_ready, res_we;
  logic [31:0] res_data;
  logic [4:0]  res_rd, wb_rd;
  logic        wb_valid, illegal, err, busy;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  fir_xifu_offload dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_instr_i(req_instr), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .xif_issue_valid_o(iss_valid), .xif_issue_ready_i(iss_ready),
    .xif_issue_instr_o(iss_instr), .xif_issue_rs1_o(iss_rs1), .xif_issue_rs2_o(iss_rs2),
    .xif_issue_id_o(iss_id), .xif_issue_accept_i(iss_accept), .xif_issue_writeback_i(iss_wb),
    .xif_commit_valid_o(cmt_valid), .xif_commit_id_o(cmt_id), .xif_commit_kill_o(cmt_kill),
    .xif_result_valid_i(res_valid), .xif_result_ready_o(res_ready),
    .xif_result_id_i(res_id), .xif_result_data_i(res_data),
    .xif_result_rd_i(res_rd), .xif_result_we_i(res_we),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .illegal_o(illegal), .err_o(err), .busy_o(busy)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int outst[$];   // IDs awaiting a result
  int nid;        // ID for the next issue
  bit merr;       // sticky error

  function automatic bit in_flight(input int id);
    foreach (outst[i]) if (outst[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void retire(input int id);
    for (int i = 0; i < outst.size(); i++)
      if (outst[i] == id) begin outst.delete(i); break; end
  endfunction

  function automatic bit mdl_ready();
    return (outst.size() < 4) && !in_flight(nid);
  endfunction

  function automatic void mdl_reset();
    outst.delete(); nid = 0; merr = 1'b0;
  endfunction

  // ---------------- transactions (entered and left at a negedge) ----------------
  task automatic offload(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit acc, input bit wbk,
                         input bit ren, input int rid, input logic [4:0] rrd,
                         input logic [31:0] rdat, input bit rwe);
    int id; bit hit, exp_wb;
    chk("req_ready_idle", req_ready, mdl_ready());
    req_valid = 1'b1; req_instr = ins; req_rs1 = a; req_rs2 = b;
    @(negedge clk);
    req_valid = 1'b0; req_instr = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
    id = nid;
    for (int c = 0; c <= stall; c++) begin
      chk("iss_valid", iss_valid, 1);
      chk("iss_instr", iss_instr, ins);
      chk("iss_rs1", iss_rs1, a);
      chk("iss_rs2", iss_rs2, b);
      chk("iss_id", iss_id, id);
      chk("req_ready_stall", req_ready, 0);
      chk("cmt_quiet", cmt_valid, 0);
      iss_ready  = (c == stall);
      iss_accept = (c == stall) ? acc : 1'($urandom);
      iss_wb     = (c == stall) ? wbk : 1'($urandom);
      if (c == stall && ren) begin
        res_valid = 1'b1; res_id = 4'(rid); res_rd = rrd; res_data = rdat; res_we = rwe;
      end
      @(negedge clk);
    end
    iss_ready = 1'b0; res_valid = 1'b0;
    hit = ren && in_flight(rid);
    if (ren) begin
      if (hit) retire(rid); else merr = 1'b1;
    end
    if (acc && wbk) outst.push_back(id);
    nid = (nid + 1) % 16;
    chk("cmt_valid", cmt_valid, 1);
    chk("cmt_id", cmt_id, id);
    chk("cmt_kill", cmt_kill, !acc);
    chk("illegal", illegal, !acc);
    chk("iss_valid_done", iss_valid, 0);
    exp_wb = hit && rwe && (rrd != 5'd0);
    chk("wb_valid_sim", wb_valid, exp_wb);
    if (exp_wb) begin
      chk("wb_rd_sim", wb_rd, rrd);
      chk("wb_data_sim", wb_data, rdat);
    end
    chk("err", err, merr);
    @(negedge clk);
    chk("cmt_pulse", cmt_valid, 0);
    chk("illegal_pulse", illegal, 0);
    chk("wb_pulse", wb_valid, 0);
    chk("busy", busy, outst.size() != 0);
  endtask

  task automatic result(input int rid, input logic [4:0] rd, input logic [31:0] d, input bit we);
    bit hit, exp_wb;
    hit = in_flight(rid);
    chk("res_ready", res_ready, 1);
    res_valid = 1'b1; res_id = 4'(rid); res_rd = rd; res_data = d; res_we = we;
    @(negedge clk);
    res_valid = 1'b0;
    if (hit) retire(rid); else merr = 1'b1;
    exp_wb = hit && we && (rd != 5'd0);
    chk("wb_valid", wb_valid, exp_wb);
    if (exp_wb) begin
      chk("wb_rd", wb_rd, rd);
      chk("wb_data", wb_data, d);
    end
    chk("err_res", err, merr);
    chk("req_ready_after_res", req_ready, mdl_ready());
    chk("busy_res", busy, outst.size() != 0);
    @(negedge clk);
    chk("wb_pulse_res", wb_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_cmt_valid", cmt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    mdl_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reset in the middle of ISSUE (in_commit=0) or COMMIT (in_commit=1).
  task automatic rst_mid(input bit in_commit);
    req_valid = 1'b1; req_instr = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_iss_valid", iss_valid, 1);
    if (in_commit) begin
      iss_ready = 1'b1; iss_accept = 1'b1; iss_wb = 1'b1;
      @(negedge clk);
      iss_ready = 1'b0;
      chk("mid_cmt_valid", cmt_valid, 1);
    end
    do_reset();
    for (int c = 0; c < 3; c++) begin
      chk("post_rst_cmt", cmt_valid, 0);
      chk("post_rst_iss", iss_valid, 0);
      chk("post_rst_busy", busy, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    req_valid = 0; req_instr = 0; req_rs1 = 0; req_rs2 = 0;
    iss_ready = 0; iss_accept = 0; iss_wb = 0;
    res_valid = 0; res_id = 0; res_data = 0; res_rd = 0; res_we = 0;
    mdl_reset();

    // Reset state
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_instr", iss_instr, 0);
    chk("rst_iss_id", iss_id, 0);
    chk("rst_cmt_valid", cmt_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_ready", res_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Single instruction
    offload(32'h0000_500B, 32'd3, 32'd5, 0, 1, 1, 0, 0, 0, 0, 0);
    result(0, 5'd10, 32'h1234, 1);

    // Back-pressure: 5 stalled cycles + handshake cycle = 6 stable cycles
    offload($urandom, $urandom, $urandom, 5, 1, 0, 0, 0, 0, 0, 0);

    // Rejection
    offload($urandom, $urandom, $urandom, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("reject_not_busy", busy, 0);

    // Capacity
    for (int k = 0; k < 4; k++) offload($urandom, $urandom, $urandom, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("full_req_ready", req_ready, 0);
    result(outst[1], 5'd7, $urandom, 1);
    chk("room_req_ready", req_ready, 1);
    // Issue and retire in the same cycle: count stays at 3
    offload($urandom, $urandom, $urandom, 1, 1, 1, 1, outst[0], 5'd9, 32'hCAFE, 1);
    offload($urandom, $urandom, $urandom, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("full_again", req_ready, 0);
    while (outst.size() > 0) result(outst[0], 5'($urandom_range(0, 31)), $urandom, 1'($urandom));

    // ID wrap: 16 untracked issues
    for (int k = 0; k < 16; k++) offload($urandom, $urandom, $urandom, 0, 1, 0, 0, 0, 0, 0, 0);

    // Unknown result ID 7 -> sticky error, no writeback
    if (in_flight(7)) result(7, 5'd1, 0, 1);
    result(7, 5'd3, 32'hDEAD, 1);
    @(negedge clk);
    chk("err_sticky", err, 1);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      int op; int rid;
      op = $urandom_range(0, 2);
      if (!mdl_ready() || (op == 0 && outst.size() > 0)) begin
        if (outst.size() > 0 && $urandom_range(0, 9) != 0)
          rid = outst[$urandom_range(0, outst.size() - 1)];
        else
          rid = $urandom_range(0, 15);
        result(rid, 5'($urandom_range(0, 31)), $urandom, 1'($urandom));
      end else begin
        bit ren;
        ren = (outst.size() > 0) && ($urandom_range(0, 2) == 0);
        rid = (outst.size() > 0) ? outst[$urandom_range(0, outst.size() - 1)] : 0;
        offload($urandom, $urandom, $urandom, $urandom_range(0, 2),
                ($urandom_range(0, 3) != 0), 1'($urandom),
                ren, rid, 5'($urandom_range(0, 31)), $urandom, 1'($urandom));
      end
    end

    // Reset abandons an in-flight transaction
    rst_mid(0);
    rst_mid(1);
    offload($urandom, $urandom, $urandom, 0, 1, 1, 0, 0, 0, 0, 0);

`ifdef FIR_XIFU_OFFLOAD_TIMEOUT_EN
    begin
      int cyc; bit saw_cmt;
      do_reset();
      req_valid = 1'b1; req_instr = $urandom;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 0; saw_cmt = 0;
      while (iss_valid && cyc < 400) begin
        cyc++;
        if (cmt_valid) saw_cmt = 1;
        @(negedge clk);
      end
      chk("to_cycles", cyc, 255);
      chk("to_no_cmt", saw_cmt, 0);
      chk("to_err", err, 1);
      chk("to_idle_ready", req_ready, 1);
      merr = 1'b1;
      offload($urandom, $urandom, $urandom, 0, 1, 0, 0, 0, 0, 0, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
